// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: MULT/DIV opcode encodings, sequencer states, default width.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_MULT_RUN,
        MD_DIV_RUN,
        MD_FIX,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One unsigned restoring-division iteration: shift {rem,quo} left, trial-subtract divisor, keep if non-negative.
module div_restore_step
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {2'b00, divisor_i};

    // Keep the trial difference when its sign bit is clear, otherwise restore.
    always_comb begin
        rem_o = shifted[WIDTH:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            rem_o    = trial[WIDTH:0];
            quo_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring + sign fix) engine feeding HI/LO.
module mult_div_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc/q/m double as rem/quo/|divisor| during DIV; the two operations never overlap.
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [WIDTH:0]   m_q, m_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_q;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH-1:0] div_quo;

    div_restore_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i     (acc_q),
        .quo_i     (q_q),
        .divisor_i (m_q[WIDTH-1:0]),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    // Booth add/subtract selected by {q[0], q_1}, followed by arithmetic shift right.
    always_comb begin
        booth_sum = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   booth_sum = acc_q + m_q;
            2'b10:   booth_sum = acc_q - m_q;
            default: booth_sum = acc_q;
        endcase
    end

    assign booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (op)
                        MD_OP_MULT: begin
                            state_d = MD_MULT_RUN;
                            acc_d   = '0;
                            q_d     = b;
                            q1_d    = 1'b0;
                            m_d     = {a[WIDTH-1], a};
                            cnt_d   = '0;
                        end
                        MD_OP_DIV: begin
                            if (b == '0) begin
                                div0_d = 1'b1;
                            end else begin
                                state_d  = MD_DIV_RUN;
                                sign_a_d = a[WIDTH-1];
                                sign_b_d = b[WIDTH-1];
                                acc_d    = '0;
                                q_d      = a[WIDTH-1] ? -a : a;
                                m_d      = {1'b0, (b[WIDTH-1] ? -b : b)};
                                cnt_d    = '0;
                            end
                        end
                        default: state_d = MD_IDLE;
                    endcase
                end
            end
            MD_MULT_RUN: begin
                acc_d = booth_acc;
                q_d   = booth_q;
                q1_d  = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    hi_d    = booth_acc[WIDTH-1:0];
                    lo_d    = booth_q;
                    state_d = MD_DONE;
                    done_d  = 1'b1;
                end
            end
            MD_DIV_RUN: begin
                acc_d = div_rem;
                q_d   = div_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                lo_d    = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
                hi_d    = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                state_d = MD_DONE;
                done_d  = 1'b1;
            end
            MD_DONE: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign busy = (state_q == MD_MULT_RUN) || (state_q == MD_DIV_RUN) || (state_q == MD_FIX);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Randomized + directed bench for mult_div_sequencer against a plain-arithmetic reference model.
module tb_mult_div_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned checks;
    int unsigned failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation; repulse>0 re-asserts start with junk operands in that busy cycle.
    task automatic do_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                         input int repulse);
        longint      pa;
        longint      pb;
        logic [63:0] res;
        logic [63:0] qv;
        logic [63:0] rv;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
        int          cyc;

        pa = longint'($signed(a_v));
        pb = longint'($signed(b_v));
        exp_hi = m_hi;
        exp_lo = m_lo;
        exp_lat = 0;
        if (op_v == 1'b0) begin
            res     = pa * pb;
            exp_hi  = res[63:32];
            exp_lo  = res[31:0];
            exp_lat = 33;
        end else if (pb != 0) begin
            qv      = pa / pb;
            rv      = pa % pb;
            exp_hi  = rv[31:0];
            exp_lo  = qv[31:0];
            exp_lat = 34;
        end

        @(negedge clk);
        start = 1'b1; op = op_v; a = a_v; b = b_v;
        @(negedge clk);
        start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;

        if (op_v == 1'b1 && pb == 0) begin
            check("div0_pulse", div0, 1);
            check("div0_busy", busy, 0);
            check("div0_nodone", done, 0);
            check("div0_hi_keep", hi, m_hi);
            check("div0_lo_keep", lo, m_lo);
            @(negedge clk);
            check("div0_onecycle", div0, 0);
            check("div0_nodone2", done, 0);
            check("div0_busy2", busy, 0);
            return;
        end

        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            check("busy", busy, 1);
            check("hold_hi", hi, m_hi);
            check("hold_lo", lo, m_lo);
            check("no_div0", div0, 0);
            start = (cyc == repulse);
            if (start) begin
                op = 1'($urandom); a = $urandom; b = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        check("latency", 64'(cyc), 64'(exp_lat));
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("done_div0", div0, 0);
        check(op_v ? "div_hi" : "mul_hi", hi, exp_hi);
        check(op_v ? "div_lo" : "mul_lo", lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;

        // start during the DONE cycle must be ignored (b=0 would also expose a stray div0)
        start = 1'b1; op = 1'($urandom); a = $urandom; b = '0;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_len", done, 0);
        check("done_start_ignored", busy, 0);
        check("done_start_nodiv0", div0, 0);
        check("after_hi", hi, m_hi);
        check("after_lo", lo, m_lo);
    endtask

    // Start an op, then pulse reset during cycle `at` and confirm a clean abort.
    task automatic reset_mid(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                             input int at);
        bit seen;
        @(negedge clk);
        start = 1'b1; op = op_v; a = a_v; b = b_v;
        @(negedge clk);
        start = 1'b0;
        repeat (at - 1) @(negedge clk);
        check("rst_mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div0", div0, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        m_hi = '0;
        m_lo = '0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check("rst_no_done", seen, 0);
    endtask

    initial begin
        logic        rop;
        logic [31:0] ra;
        logic [31:0] rb;

        checks = 0;
        failures = 0;
        m_hi = '0;
        m_lo = '0;
        reset = 1'b1;
        start = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_div0", div0, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        reset = 1'b0;

        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(1'b1, 32'd100, 32'd7, 0);
        do_op(1'b0, 32'h0001_2345, 32'h0000_0F0F, 0);
        do_op(1'b1, 32'd5, 32'd0, 0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(1'b0, 32'd1234, 32'hFFFF_FF00, 10);
        reset_mid(1'b1, 32'd1000, 32'd3, 15);
        do_op(1'b0, 32'd3, 32'd4, 0);

        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom);
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($signed(16'($urandom)));
            do_op(rop, ra, rb, (i % 5 == 0) ? int'($urandom_range(1, 30)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Iterative signed MULT/DIV engine with its own controller. It feeds the HI/LO registers of the multicycle MIPS datapath.
- The main control FSM pulses start with op/a/b, then waits on busy/done before issuing MFHI/MFLO.
- A zero divisor raises div0, which the main FSM routes to the ZeroDiv exception state.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = MULT, 1 = DIV; sampled with start
- a  in  WIDTH  multiplicand / dividend (signed); sampled with start
- b  in  WIDTH  multiplier / divisor (signed); sampled with start
- busy  out  1  high in MULT_RUN, DIV_RUN, FIX
- done  out  1  one-cycle pulse; hi/lo hold the new result in that cycle
- div0  out  1  one-cycle pulse on DIV with b == 0
- hi  out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
- lo  out  WIDTH  MULT: product[W-1:0]; DIV: quotient

Behaviour:
- Reset: state=IDLE, counter=0, busy=0, done=0, div0=0, hi=0, lo=0. Reset in any state, including mid-operation, aborts with no done/div0 and clears hi/lo.
- States: IDLE, MULT_RUN, DIV_RUN, FIX, DONE. Edge 0 is the edge on which start is sampled.
- IDLE:
  - start & op=0 -> MULT_RUN: acc=0 (WIDTH+1 bits), q={b}, q_1=0, m=a (sign-extended to WIDTH+1), counter=0.
  - start & op=1 & b==0 -> IDLE. div0=1 for exactly the following cycle; hi/lo unchanged; done not asserted.
  - start & op=1 & b!=0 -> DIV_RUN: capture sign_a, sign_b, |a|, |b| as unsigned; rem=0 (WIDTH+1 bits), quo=|a|, counter=0.
- MULT_RUN: radix-2 Booth, one step per edge.
  - {q[0],q_1}=01: acc+=m; =10: acc-=m; else no add.
  - Then arithmetic shift right of {acc,q,q_1} by 1.
  - Accumulator is WIDTH+1 bits, so a = -2^(W-1) does not overflow.
  - After step WIDTH (edge WIDTH): hi<=acc[W-1:0], lo<=q -> DONE.
- DIV_RUN: unsigned restoring, one step per edge.
  - Shift {rem,quo} left by 1, then trial t = rem - |b|.
  - If t >= 0: rem=t, quo[0]=1; else restore.
  - After step WIDTH (edge WIDTH) -> FIX.
- FIX, one edge (edge WIDTH+1):
  - lo <= (sign_a^sign_b) ? -quo : quo.
  - hi <= sign_a ? -rem : rem.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - -2^(W-1) / -1 yields lo=0x80000000, hi=0 (decided; no overflow flag).
  - -> DONE.
- DONE: done=1 for this single cycle -> IDLE on the next edge.
- Latency: MULT done visible in the cycle after edge WIDTH (33rd cycle after start for W=32). DIV done one cycle later (34th).
- hi/lo change only at the final writing edge or on reset; during busy they hold the previous result.
- start outside IDLE is ignored (no queuing), including in DONE. op/a/b are ignored when start=0.
- done and div0 are never high together. Both are registered outputs, not combinational.

Decomposition:
- Shared package mips_pkg:
  - MD_OP_MULT/MD_OP_DIV encodings.
  - md_state_t enum (IDLE, MULT_RUN, DIV_RUN, FIX, DONE).
  - WIDTH default constant.
- One sub-module: div_restore_step. Combinational single restoring iteration: in rem, quo, divisor; out rem', quo'.
- Booth step stays inline.

Test Plan:
- MULT a=7, b=-3 (0xFFFFFFFD) -> busy 32 cycles, done pulse in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; MULT 0xFFFFFFFF*0xFFFFFFFF -> hi=0, lo=1.
- DIV a=-7, b=2 -> done in cycle 34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 100/7 -> lo=14, hi=2.
- DIV a=5, b=0 after a prior MULT result -> div0 high exactly one cycle, busy stays 0, no done, hi/lo retain prior values.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- start re-pulsed with different operands at cycle 10 of a MULT -> ignored, original result returned. reset at cycle 15 of a DIV -> next cycle busy=0, hi=lo=0, no done. A following MULT 3*4 -> lo=12.
